encoder_rr_arbiter: RTL and testbench

//   Round-robin arbiter sharing one downstream resource between 4 requesters.

---
 rtl/encoder_rr_arbiter.sv | 120 ++++++++++++
 tb/tb_encoder_rr_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/encoder_rr_arbiter.sv
// Round-robin arbiter for four requesters sharing the priority-encoder datapath.
// Each grant lasts at most MAX_HOLD cycles, and one dead cycle follows every release.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         arbiter enable; low blocks new grants and revokes the current one
//   req[3:0]   request vector, one bit per requester
//   gnt[3:0]   registered one-hot grant (0000 when idle)
//   gnt_id     registered encoded index of the granted requester
//   gnt_valid  registered, high while a grant is held (== |gnt)
//   timeout    registered one-cycle pulse in the dead cycle after a MAX_HOLD release
module encoder_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam int unsigned HOLD_W = 8;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_nx;
  logic [HOLD_W-1:0] hold_cnt, hold_nx;
  logic [1:0]        last_id, last_nx;
  logic [3:0]        gnt_nx;
  logic [1:0]        id_nx;
  logic              valid_nx;
  logic              timeout_nx;
  logic [1:0]        winner;

  // First set request bit searching last+1, last+2, last+3, last+4 (mod 4).
  function automatic logic [1:0] pick(input logic [1:0] last, input logic [3:0] r);
    logic [1:0] w;
    logic [1:0] idx;
    logic       found;
    w     = last;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && r[idx]) begin
        w     = idx;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      last_id   <= 2'd3;
      gnt       <= 4'b0000;
      gnt_id    <= 2'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nx;
      hold_cnt  <= hold_nx;
      last_id   <= last_nx;
      gnt       <= gnt_nx;
      gnt_id    <= id_nx;
      gnt_valid <= valid_nx;
      timeout   <= timeout_nx;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nx   = state;
    hold_nx    = hold_cnt;
    last_nx    = last_id;
    gnt_nx     = gnt;
    id_nx      = gnt_id;
    valid_nx   = gnt_valid;
    timeout_nx = 1'b0;
    winner     = pick(last_id, req);

    case (state)
      IDLE: begin
        if (en && (req != 4'b0000)) begin
          state_nx = BUSY;
          gnt_nx   = 4'b0001 << winner;
          id_nx    = winner;
          valid_nx = 1'b1;
          hold_nx  = '0;
        end
      end
      BUSY: begin
        // Enable loss and request drop win over the hold limit, so no pulse then.
        if (!en || !req[gnt_id] || (hold_cnt == HOLD_LAST)) begin
          state_nx   = IDLE;
          gnt_nx     = 4'b0000;
          valid_nx   = 1'b0;
          last_nx    = gnt_id;
          hold_nx    = '0;
          timeout_nx = en && req[gnt_id];
        end else begin
          hold_nx = hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        gnt_nx   = 4'b0000;
        valid_nx = 1'b0;
        hold_nx  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_encoder_rr_arbiter.sv
// Directed-vector bench for encoder_rr_arbiter (MAX_HOLD=8) with a scoreboard queue.
module tb_encoder_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  typedef struct {
    string      name;
    logic [3:0] g;
    logic [1:0] id;
    logic       to;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  encoder_rr_arbiter #(.MAX_HOLD(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req_v);
    n_chk++;
    if (act === req_v) n_pass++;
    else $display("FAIL %s: got {gnt,valid,id,timeout}=%b required %b at %0t", name, act, req_v, $time);
  endtask

  // Scoreboard monitor: one expectation per clock edge, sampled 1 time unit after it.
  exp_t m_e;
  logic [1:0] m_id;
  always @(posedge clk) begin
    #1;
    if (rst_n && exp_q.size() > 0) begin
      m_e  = exp_q.pop_front();
      m_id = (m_e.g != 4'b0000) ? gnt_id : 2'd0;
      chk(m_e.name, {gnt, gnt_valid, m_id, timeout},
          {m_e.g, (m_e.g != 4'b0000), m_e.id, m_e.to});
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic cyc(input string name, input logic e, input logic [3:0] r,
                     input logic [3:0] eg, input logic [1:0] eid, input logic et);
    exp_t x;
    en   = e;
    req  = r;
    x.name = name;
    x.g    = eg;
    x.id   = (eg != 4'b0000) ? eid : 2'd0;
    x.to   = et;
    exp_q.push_back(x);
    @(negedge clk);
  endtask

  task automatic do_reset(input string name);
    rst_n = 1'b0;
    @(negedge clk);
    chk(name, {gnt, gnt_valid, gnt_id, timeout}, 8'h00);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running required finished");
    $fatal(1);
  end

  initial begin
    logic [3:0] oh;
    rst_n = 1'b0;
    en    = 1'b1;
    req   = 4'b1111;

    // Reset held with all requests pending.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_hold", {gnt, gnt_valid, gnt_id, timeout}, 8'h00);
    end
    rst_n = 1'b1;

    // Single requester, released by request drop.
    cyc("single_grant", 1'b1, 4'b0100, 4'b0100, 2'd2, 1'b0);
    cyc("single_hold",  1'b1, 4'b0100, 4'b0100, 2'd2, 1'b0);
    cyc("single_drop",  1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);
    cyc("single_idle",  1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);

    // Starvation: all requesting, each grant 8 cycles then a timeout dead cycle.
    do_reset("reset_pre_starve");
    for (int g = 0; g < 5; g++) begin
      oh = 4'b0001 << (g % 4);
      for (int c = 0; c < 8; c++)
        cyc("starve_grant", 1'b1, 4'b1111, oh, 2'(g % 4), 1'b0);
      cyc("starve_dead", 1'b1, 4'b1111, 4'b0000, 2'd0, 1'b1);
    end
    cyc("starve_end", 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);

    // Enable gating.
    do_reset("reset_pre_en");
    for (int c = 0; c < 20; c++)
      cyc("en_low", 1'b0, 4'b0011, 4'b0000, 2'd0, 1'b0);
    cyc("en_rise",  1'b1, 4'b0011, 4'b0001, 2'd0, 1'b0);
    cyc("en_hold",  1'b1, 4'b0011, 4'b0001, 2'd0, 1'b0);
    cyc("en_drop",  1'b0, 4'b0011, 4'b0000, 2'd0, 1'b0);
    cyc("en_idle",  1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0);

    // Rotation: last_id=0 here.
    cyc("rot_g1",    1'b1, 4'b0010, 4'b0010, 2'd1, 1'b0);
    cyc("rot_rel1",  1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);
    cyc("rot_g3",    1'b1, 4'b1011, 4'b1000, 2'd3, 1'b0);
    cyc("rot_g3h",   1'b1, 4'b1011, 4'b1000, 2'd3, 1'b0);
    cyc("rot_rel3",  1'b1, 4'b0011, 4'b0000, 2'd0, 1'b0);
    cyc("rot_g0",    1'b1, 4'b0011, 4'b0001, 2'd0, 1'b0);
    cyc("rot_rel0",  1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);

    // Request drop coinciding with the hold limit: no timeout pulse.
    for (int c = 0; c < 8; c++)
      cyc("drop_lim_grant", 1'b1, 4'b0001, 4'b0001, 2'd0, 1'b0);
    cyc("drop_lim_rel",  1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);
    cyc("drop_lim_idle", 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);

    // Enable loss coinciding with the hold limit: no timeout pulse.
    for (int c = 0; c < 8; c++)
      cyc("en_lim_grant", 1'b1, 4'b0100, 4'b0100, 2'd2, 1'b0);
    cyc("en_lim_rel",  1'b0, 4'b0100, 4'b0000, 2'd0, 1'b0);
    cyc("en_lim_idle", 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0);

    // Async reset mid-grant (last_id=2, so requester 1 wins).
    cyc("async_g1",  1'b1, 4'b0010, 4'b0010, 2'd1, 1'b0);
    cyc("async_g1h", 1'b1, 4'b0010, 4'b0010, 2'd1, 1'b0);
    @(posedge clk);
    #2;
    chk("async_pre", {gnt, gnt_valid, gnt_id, timeout}, {4'b0010, 1'b1, 2'd1, 1'b0});
    rst_n = 1'b0;
    #1;
    chk("async_clear", {gnt, gnt_valid, timeout}, 8'({4'b0000, 1'b0, 1'b0}));
    @(negedge clk);
    rst_n = 1'b1;
    cyc("post_reset_g0", 1'b1, 4'b1111, 4'b0001, 2'd0, 1'b0);
    cyc("post_reset_rel", 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
